// File: rtl/exit_park.sv
// exit_park: single-lane exit controller for a small car park.
// An exit request latches the space number. The space's occupancy bit is
// then checked. A valid exit clears that space, opens the gate for
// GATE_CYCLES cycles, waits for the gate to report closed and counts the
// exit. A request for an unoccupied space produces a one-cycle error pulse.
//
// Ports:
//   clk              system clock, rising-edge active
//   rst_n            asynchronous active-low reset
//   exit             exit request (level, sampled only when idle)
//   exit_space[2:0]  space being vacated, valid with exit
//   parking_capacity occupancy bitmap, bit n = 1 -> space n occupied
//   gate_closed      gate position sensor, 1 = fully closed
//   clear_mask[7:0]  one-cycle one-hot strobe clearing the vacated space
//   gate_open        gate drive, 1 = open
//   exit_error       one-cycle pulse when the requested space is empty
//   busy             high whenever the controller is not idle
//   exit_count[7:0]  successful exits, wraps 255 -> 0
module exit_park #(
    parameter int unsigned GATE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       exit,
    input  logic [2:0] exit_space,
    input  logic [7:0] parking_capacity,
    input  logic       gate_closed,
    output logic [7:0] clear_mask,
    output logic       gate_open,
    output logic       exit_error,
    output logic       busy,
    output logic [7:0] exit_count
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        OPEN,
        WAIT_CLOSE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [2:0] r_space;
    logic [7:0] r_timer;
    logic [7:0] r_clear_mask;
    logic       r_gate_open;
    logic       r_exit_error;
    logic       r_busy;
    logic [7:0] r_exit_count;

    logic [2:0] w_space_nxt;
    logic [7:0] w_timer_nxt;
    logic [7:0] w_clear_mask_nxt;
    logic       w_gate_open_nxt;
    logic       w_exit_error_nxt;
    logic       w_busy_nxt;
    logic [7:0] w_exit_count_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (exit) w_state_nxt = CHECK;
            CHECK:      w_state_nxt = parking_capacity[r_space] ? OPEN : IDLE;
            OPEN:       if (r_timer == '0) w_state_nxt = WAIT_CLOSE;
            WAIT_CLOSE: if (gate_closed) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Output logic: computes the next value of every registered output so
    // that all outputs change on the same edge as the state they belong to.
    always_comb begin
        w_space_nxt      = r_space;
        w_timer_nxt      = r_timer;
        w_clear_mask_nxt = '0;
        w_gate_open_nxt  = r_gate_open;
        w_exit_error_nxt = 1'b0;
        w_exit_count_nxt = r_exit_count;
        w_busy_nxt       = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                if (exit) w_space_nxt = exit_space;
            end
            CHECK: begin
                if (parking_capacity[r_space]) begin
                    w_clear_mask_nxt = 8'd1 << r_space;
                    w_gate_open_nxt  = 1'b1;
                    w_timer_nxt      = 8'(GATE_CYCLES - 1);
                    w_exit_count_nxt = r_exit_count + 8'd1;
                end else begin
                    w_exit_error_nxt = 1'b1;
                end
            end
            OPEN: begin
                // Timer loaded with GATE_CYCLES-1; the gate drops on the
                // edge that sees zero, giving exactly GATE_CYCLES open cycles.
                if (r_timer == '0) begin
                    w_gate_open_nxt = 1'b0;
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            WAIT_CLOSE: begin
                w_gate_open_nxt = 1'b0;
            end
            default: begin
                w_gate_open_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_space      <= '0;
            r_timer      <= '0;
            r_clear_mask <= '0;
            r_gate_open  <= 1'b0;
            r_exit_error <= 1'b0;
            r_busy       <= 1'b0;
            r_exit_count <= '0;
        end else begin
            r_space      <= w_space_nxt;
            r_timer      <= w_timer_nxt;
            r_clear_mask <= w_clear_mask_nxt;
            r_gate_open  <= w_gate_open_nxt;
            r_exit_error <= w_exit_error_nxt;
            r_busy       <= w_busy_nxt;
            r_exit_count <= w_exit_count_nxt;
        end
    end

    assign clear_mask = r_clear_mask;
    assign gate_open  = r_gate_open;
    assign exit_error = r_exit_error;
    assign busy       = r_busy;
    assign exit_count = r_exit_count;

endmodule

// File: tb/tb_exit_park.sv
module tb_exit_park;

    logic       clk;
    logic       rst_n;
    logic       exit;
    logic [2:0] exit_space;
    logic [7:0] parking_capacity;
    logic       gate_closed;
    logic [7:0] clear_mask;
    logic       gate_open;
    logic       exit_error;
    logic       busy;
    logic [7:0] exit_count;

    int tests;
    int failures;

    exit_park #(.GATE_CYCLES(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .exit             (exit),
        .exit_space       (exit_space),
        .parking_capacity (parking_capacity),
        .gate_closed      (gate_closed),
        .clear_mask       (clear_mask),
        .gate_open        (gate_open),
        .exit_error       (exit_error),
        .busy             (busy),
        .exit_count       (exit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        tests++; if (clear_mask !== 8'h00) begin failures++; $display("FAIL reset_clear_mask got %h exp 00", clear_mask); end
        tests++; if (gate_open !== 1'b0) begin failures++; $display("FAIL reset_gate_open got %b exp 0", gate_open); end
        tests++; if (exit_error !== 1'b0) begin failures++; $display("FAIL reset_exit_error got %b exp 0", exit_error); end
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (exit_count !== 8'h00) begin failures++; $display("FAIL reset_count got %0d exp 0", exit_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_valid_exit();
        parking_capacity = 8'b0010_0100;
        gate_closed = 1'b0;
        exit = 1'b1; exit_space = 3'd5;
        tick(); // IDLE -> CHECK
        exit = 1'b0;
        tests++; if (busy !== 1'b1) begin failures++; $display("FAIL valid_busy_check got %b exp 1", busy); end
        tests++; if (clear_mask !== 8'h00) begin failures++; $display("FAIL valid_clear_early got %h exp 00", clear_mask); end
        tick(); // CHECK -> OPEN
        tests++; if (clear_mask !== 8'b0010_0000) begin failures++; $display("FAIL valid_clear_mask got %b exp 00100000", clear_mask); end
        tests++; if (exit_count !== 8'd1) begin failures++; $display("FAIL valid_count got %0d exp 1", exit_count); end
        tests++; if (gate_open !== 1'b1) begin failures++; $display("FAIL valid_gate_c1 got %b exp 1", gate_open); end
        for (int i = 2; i <= 4; i++) begin
            tick();
            tests++; if (gate_open !== 1'b1) begin failures++; $display("FAIL valid_gate_c%0d got %b exp 1", i, gate_open); end
        end
        tests++; if (clear_mask !== 8'h00) begin failures++; $display("FAIL valid_clear_one_cycle got %h exp 00", clear_mask); end
        tick(); // OPEN -> WAIT_CLOSE
        tests++; if (gate_open !== 1'b0) begin failures++; $display("FAIL valid_gate_c5 got %b exp 0", gate_open); end
        tests++; if (busy !== 1'b1) begin failures++; $display("FAIL valid_busy_wait got %b exp 1", busy); end
        gate_closed = 1'b1;
        tick(); // WAIT_CLOSE -> IDLE
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL valid_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_empty_space();
        parking_capacity = 8'b0000_0001;
        exit = 1'b1; exit_space = 3'd3;
        tick();
        exit = 1'b0;
        tests++; if (busy !== 1'b1) begin failures++; $display("FAIL empty_busy got %b exp 1", busy); end
        tick();
        tests++; if (exit_error !== 1'b1) begin failures++; $display("FAIL empty_error got %b exp 1", exit_error); end
        tests++; if (clear_mask !== 8'h00) begin failures++; $display("FAIL empty_clear got %h exp 00", clear_mask); end
        tests++; if (gate_open !== 1'b0) begin failures++; $display("FAIL empty_gate got %b exp 0", gate_open); end
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy_end got %b exp 0", busy); end
        tests++; if (exit_count !== 8'd1) begin failures++; $display("FAIL empty_count got %0d exp 1", exit_count); end
        tick();
        tests++; if (exit_error !== 1'b0) begin failures++; $display("FAIL empty_error_pulse got %b exp 0", exit_error); end
    endtask

    task automatic test_request_while_busy();
        int pulses;
        pulses = 0;
        parking_capacity = 8'b0010_0100;
        gate_closed = 1'b1; // closed sensor during OPEN must not shorten it
        exit = 1'b1; exit_space = 3'd5;
        tick();
        exit = 1'b0;
        tick();
        if (clear_mask != 8'h00) pulses++;
        exit = 1'b1; exit_space = 3'd2;
        tick();
        if (clear_mask != 8'h00) pulses++;
        tick();
        if (clear_mask != 8'h00) pulses++;
        exit = 1'b0;
        tick();
        if (clear_mask != 8'h00) pulses++;
        tests++; if (gate_open !== 1'b1) begin failures++; $display("FAIL busy_gate_c4 got %b exp 1", gate_open); end
        tick();
        tests++; if (gate_open !== 1'b0) begin failures++; $display("FAIL busy_gate_c5 got %b exp 0", gate_open); end
        tick();
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_idle got %b exp 0", busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (clear_mask != 8'h00) pulses++;
        end
        tests++; if (pulses !== 1) begin failures++; $display("FAIL busy_pulses got %0d exp 1", pulses); end
        tests++; if (exit_count !== 8'd2) begin failures++; $display("FAIL busy_count got %0d exp 2", exit_count); end
    endtask

    task automatic test_gate_stuck();
        int bad;
        bad = 0;
        parking_capacity = 8'b0010_0000;
        gate_closed = 1'b0;
        exit = 1'b1; exit_space = 3'd5;
        tick();
        exit = 1'b0;
        for (int i = 0; i < 5; i++) tick(); // CHECK->OPEN, 4 open cycles end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b1 || gate_open !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin failures++; $display("FAIL stuck_wait bad_cycles %0d exp 0", bad); end
        gate_closed = 1'b1;
        tick();
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL stuck_release got %b exp 0", busy); end
        tests++; if (exit_count !== 8'd3) begin failures++; $display("FAIL stuck_count got %0d exp 3", exit_count); end
    endtask

    task automatic test_held_request();
        parking_capacity = 8'b0010_0000;
        gate_closed = 1'b1;
        exit = 1'b1; exit_space = 3'd5;
        for (int i = 0; i < 7; i++) tick(); // first transaction back to IDLE
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL held_idle got %b exp 0", busy); end
        tick();
        tests++; if (busy !== 1'b1) begin failures++; $display("FAIL held_restart got %b exp 1", busy); end
        exit = 1'b0;
        tick();
        tests++; if (exit_count !== 8'd5) begin failures++; $display("FAIL held_count got %0d exp 5", exit_count); end
        for (int i = 0; i < 5; i++) tick();
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL held_done got %b exp 0", busy); end
    endtask

    task automatic test_wrap();
        int timeouts;
        timeouts = 0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        parking_capacity = 8'hFF;
        gate_closed = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            exit = 1'b1; exit_space = 3'(n);
            tick();
            exit = 1'b0;
            for (int k = 0; k < 20 && busy; k++) tick();
            if (busy) timeouts++;
            if (n == 255) begin
                tests++; if (exit_count !== 8'd255) begin failures++; $display("FAIL wrap_255 got %0d exp 255", exit_count); end
            end
        end
        tests++; if (exit_count !== 8'd0) begin failures++; $display("FAIL wrap_0 got %0d exp 0", exit_count); end
        tests++; if (timeouts !== 0) begin failures++; $display("FAIL wrap_timeout got %0d exp 0", timeouts); end
    endtask

    task automatic test_reset_mid_open();
        parking_capacity = 8'b0000_0100;
        gate_closed = 1'b0;
        exit = 1'b1; exit_space = 3'd2;
        tick();
        exit = 1'b0;
        tick(); // 1st open cycle, count = 1
        tick(); // 2nd open cycle
        #2 rst_n = 1'b0;
        #1;
        tests++; if (gate_open !== 1'b0) begin failures++; $display("FAIL rst_open_gate got %b exp 0", gate_open); end
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_open_busy got %b exp 0", busy); end
        tests++; if (exit_count !== 8'd0) begin failures++; $display("FAIL rst_open_count got %0d exp 0", exit_count); end
        rst_n = 1'b1;
        parking_capacity = 8'b0000_1000;
        exit = 1'b1; exit_space = 3'd3;
        tick();
        exit = 1'b0;
        tests++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_first_req got %b exp 1", busy); end
        tick();
        tests++; if (clear_mask !== 8'b0000_1000) begin failures++; $display("FAIL rst_first_clear got %b exp 00001000", clear_mask); end
        tests++; if (exit_count !== 8'd1) begin failures++; $display("FAIL rst_first_count got %0d exp 1", exit_count); end
    endtask

    initial begin
        tests = 0;
        failures = 0;
        exit = 1'b0;
        exit_space = 3'd0;
        parking_capacity = 8'h00;
        gate_closed = 1'b1;
        rst_n = 1'b1;
        test_reset();
        test_valid_exit();
        test_empty_space();
        test_request_while_busy();
        test_gate_stuck();
        test_held_request();
        test_wrap();
        test_reset_mid_open();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
